// File: rtl/exc_ctrl.sv
// Exception / interrupt commit controller.
// Picks the highest-priority event at the commit stage, raises the CP0 write
// controls together with a pipeline flush, then hands fetch a redirect target
// through a valid/ready handshake. Every output is a register.
module exc_ctrl #(
    parameter logic [31:0] BOOT_VEC = 32'hBFC00380,
    parameter logic [11:0] GEN_OFS  = 12'h180,
    parameter logic [11:0] INT_OFS  = 12'h200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic        commit_bd,
    input  logic [6:0]  commit_exc,
    input  logic [31:0] mem_addr,
    input  logic        mem_is_store,
    input  logic        allow_int,
    input  logic        int_exl,
    input  logic        boot_exp_vec,
    input  logic        special_int_vec,
    input  logic [7:0]  interrupt_mask,
    input  logic [5:0]  hardware_int_o,
    input  logic [1:0]  software_int_o,
    input  logic [31:0] epc,
    input  logic [19:0] ebase,
    output logic        en_exp,
    output logic        exp_bd,
    output logic        exp_badv_we,
    output logic        clean_exl,
    output logic [4:0]  exp_code,
    output logic [31:0] exp_epc,
    output logic [31:0] exp_bad_vaddr,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t      state_r;
    logic        int_pend_r;

    logic        ev_s;
    logic        eret_s;
    logic [4:0]  code_s;
    logic        badv_we_s;
    logic [31:0] badv_s;
    logic [31:0] epc_s;
    logic        bd_s;
    logic [31:0] target_s;
    logic [31:0] base_s;

    // int_exl only matters to CP0 (EPC preservation); exceptions are taken regardless.
    logic        unused_s;
    assign unused_s = int_exl;

    // Prioritise the commit-stage event and precompute everything captured on acceptance.
    always_comb begin
        base_s    = {ebase, 12'h000};
        ev_s      = 1'b1;
        eret_s    = 1'b0;
        code_s    = 5'd0;
        badv_we_s = 1'b0;
        badv_s    = 32'd0;
        epc_s     = commit_bd ? (commit_pc - 32'd4) : commit_pc;
        bd_s      = commit_bd;
        if (boot_exp_vec) begin
            target_s = BOOT_VEC;
        end else begin
            target_s = base_s + {20'd0, GEN_OFS};
        end

        if (int_pend_r) begin
            code_s = 5'd0;
            if (boot_exp_vec) begin
                target_s = BOOT_VEC;
            end else if (special_int_vec) begin
                target_s = base_s + {20'd0, INT_OFS};
            end else begin
                target_s = base_s + {20'd0, GEN_OFS};
            end
        end else if (commit_exc[5]) begin
            code_s    = 5'd4;
            badv_we_s = 1'b1;
            badv_s    = commit_pc;
        end else if (commit_exc[4]) begin
            code_s = 5'd10;
        end else if (commit_exc[3]) begin
            code_s = 5'd8;
        end else if (commit_exc[2]) begin
            code_s = 5'd9;
        end else if (commit_exc[1]) begin
            code_s = 5'd12;
        end else if (commit_exc[0]) begin
            code_s    = mem_is_store ? 5'd5 : 5'd4;
            badv_we_s = 1'b1;
            badv_s    = mem_addr;
        end else if (commit_exc[6]) begin
            // eret carries no exception data, only the return target
            eret_s   = 1'b1;
            epc_s    = 32'd0;
            bd_s     = 1'b0;
            target_s = epc;
        end else begin
            ev_s = 1'b0;
        end
    end

    // Interrupt latch and the IDLE/FLUSH/REDIRECT sequencer with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            int_pend_r     <= 1'b0;
            en_exp         <= 1'b0;
            exp_bd         <= 1'b0;
            exp_badv_we    <= 1'b0;
            clean_exl      <= 1'b0;
            exp_code       <= 5'd0;
            exp_epc        <= 32'd0;
            exp_bad_vaddr  <= 32'd0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            busy           <= 1'b0;
        end else if (stall) begin
            int_pend_r <= allow_int & (|(interrupt_mask & {hardware_int_o, software_int_o}));
            case (state_r)
                IDLE: begin
                    if (commit_valid && ev_s) begin
                        state_r       <= FLUSH;
                        busy          <= 1'b1;
                        flush         <= 1'b1;
                        en_exp        <= ~eret_s;
                        clean_exl     <= eret_s;
                        exp_badv_we   <= badv_we_s;
                        exp_code      <= code_s;
                        exp_epc       <= epc_s;
                        exp_bd        <= bd_s;
                        exp_bad_vaddr <= badv_s;
                        redirect_pc   <= target_s;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                FLUSH: begin
                    state_r        <= REDIRECT;
                    flush          <= 1'b0;
                    en_exp         <= 1'b0;
                    clean_exl      <= 1'b0;
                    exp_badv_we    <= 1'b0;
                    redirect_valid <= 1'b1;
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        state_r        <= IDLE;
                        redirect_valid <= 1'b0;
                        busy           <= 1'b0;
                        redirect_pc    <= 32'd0;
                        exp_code       <= 5'd0;
                        exp_epc        <= 32'd0;
                        exp_bd         <= 1'b0;
                        exp_bad_vaddr  <= 32'd0;
                    end else begin
                        state_r <= REDIRECT;
                    end
                end
                default: begin
                    state_r        <= IDLE;
                    en_exp         <= 1'b0;
                    exp_bd         <= 1'b0;
                    exp_badv_we    <= 1'b0;
                    clean_exl      <= 1'b0;
                    exp_code       <= 5'd0;
                    exp_epc        <= 32'd0;
                    exp_bad_vaddr  <= 32'd0;
                    flush          <= 1'b0;
                    redirect_valid <= 1'b0;
                    redirect_pc    <= 32'd0;
                    busy           <= 1'b0;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: a transaction-level model predicts outputs every
// cycle, and literal expectations pin the key scenarios.
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, commit_valid, commit_bd, mem_is_store;
    logic [31:0] commit_pc, mem_addr, epc;
    logic [6:0]  commit_exc;
    logic        allow_int, int_exl, boot_exp_vec, special_int_vec;
    logic [7:0]  interrupt_mask;
    logic [5:0]  hardware_int_o;
    logic [1:0]  software_int_o;
    logic [19:0] ebase;
    logic        en_exp, exp_bd, exp_badv_we, clean_exl, flush, redirect_valid, busy;
    logic [4:0]  exp_code;
    logic [31:0] exp_epc, exp_bad_vaddr, redirect_pc;
    logic        redirect_ready;

    int n_checks = 0;
    int n_fail   = 0;
    logic cmp_en = 1'b0;

    exc_ctrl dut (
        .clk(clk), .rst(rst), .stall(stall), .commit_valid(commit_valid),
        .commit_pc(commit_pc), .commit_bd(commit_bd), .commit_exc(commit_exc),
        .mem_addr(mem_addr), .mem_is_store(mem_is_store), .allow_int(allow_int),
        .int_exl(int_exl), .boot_exp_vec(boot_exp_vec), .special_int_vec(special_int_vec),
        .interrupt_mask(interrupt_mask), .hardware_int_o(hardware_int_o),
        .software_int_o(software_int_o), .epc(epc), .ebase(ebase),
        .en_exp(en_exp), .exp_bd(exp_bd), .exp_badv_we(exp_badv_we), .clean_exl(clean_exl),
        .exp_code(exp_code), .exp_epc(exp_epc), .exp_bad_vaddr(exp_bad_vaddr),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [4:0]  code;
        logic [31:0] epc;
        logic [31:0] badv;
        logic [31:0] tgt;
        logic        badv_we;
        logic        bd;
        logic        eret;
    } ev_t;

    logic m_int;
    int   m_phase;   // 0 no event in flight, 1 flushing, 2 waiting for fetch
    ev_t  m_ev;

    function automatic ev_t predict();
        ev_t e;
        logic [31:0] base;
        logic found;
        int codes[6];
        codes = '{4, 10, 8, 9, 12, 0};
        e = '0;
        found = 1'b0;
        base = {ebase, 12'h000};
        if (m_int) begin
            found = 1'b1;
            e.code = 5'd0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (!found && commit_exc[5 - i]) begin
                    found = 1'b1;
                    e.code = (i == 5) ? (mem_is_store ? 5'd5 : 5'd4) : 5'(codes[i]);
                    if (i == 0) begin e.badv_we = 1'b1; e.badv = commit_pc; end
                    if (i == 5) begin e.badv_we = 1'b1; e.badv = mem_addr; end
                end
            end
        end
        if (!found) begin
            e.eret = 1'b1;
            e.tgt  = epc;
        end else begin
            e.epc = commit_bd ? commit_pc - 32'd4 : commit_pc;
            e.bd  = commit_bd;
            if (boot_exp_vec)                e.tgt = 32'hBFC00380;
            else if (m_int && special_int_vec) e.tgt = base + 32'h200;
            else                             e.tgt = base + 32'h180;
        end
        return e;
    endfunction

    // Model advance on each clock edge, async reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_int   <= 1'b0;
            m_phase <= 0;
            m_ev    <= '0;
        end else if (stall) begin
            m_int <= allow_int && ((interrupt_mask & {hardware_int_o, software_int_o}) != 8'd0);
            if (m_phase == 0) begin
                if (commit_valid && (m_int || commit_exc != 7'd0)) begin
                    m_phase <= 1;
                    m_ev    <= predict();
                end
            end else if (m_phase == 1) begin
                m_phase <= 2;
            end else if (redirect_ready) begin
                m_phase <= 0;
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("busy", busy, m_phase != 0);
            chk("flush", flush, m_phase == 1);
            chk("en_exp", en_exp, m_phase == 1 && !m_ev.eret);
            chk("clean_exl", clean_exl, m_phase == 1 && m_ev.eret);
            chk("exp_badv_we", exp_badv_we, m_phase == 1 && m_ev.badv_we);
            chk("redirect_valid", redirect_valid, m_phase == 2);
            if (m_phase == 0) begin
                chk("idle_code", exp_code, 32'd0);
                chk("idle_epc", exp_epc, 32'd0);
                chk("idle_badv", exp_bad_vaddr, 32'd0);
                chk("idle_bd", exp_bd, 32'd0);
                chk("idle_rpc", redirect_pc, 32'd0);
            end else if (m_phase == 1) begin
                chk("exp_code", exp_code, m_ev.code);
                chk("exp_epc", exp_epc, m_ev.epc);
                chk("exp_bad_vaddr", exp_bad_vaddr, m_ev.badv);
                chk("exp_bd", exp_bd, m_ev.bd);
            end else begin
                chk("redirect_pc", redirect_pc, m_ev.tgt);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic [31:0] pc, input logic bd, input logic [6:0] exc,
                          input logic [31:0] addr, input logic st);
        commit_valid = 1'b1; commit_pc = pc; commit_bd = bd; commit_exc = exc;
        mem_addr = addr; mem_is_store = st;
        step();
        commit_valid = 1'b0; commit_exc = 7'd0; commit_bd = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b1; commit_valid = 1'b0; commit_pc = 32'd0; commit_bd = 1'b0;
        commit_exc = 7'd0; mem_addr = 32'd0; mem_is_store = 1'b0; allow_int = 1'b0;
        int_exl = 1'b0; boot_exp_vec = 1'b0; special_int_vec = 1'b0; interrupt_mask = 8'd0;
        hardware_int_o = 6'd0; software_int_o = 2'd0; epc = 32'd0; ebase = 20'h80000;
        redirect_ready = 1'b1;
        step(); step();
        chk("reset_busy", busy, 32'd0);
        chk("reset_flush", flush, 32'd0);
        rst = 1'b0;
        cmp_en = 1'b1;
        step();

        // syscall, not in delay slot
        commit(32'h80001000, 1'b0, 7'b0001000, 32'd0, 1'b0);
        chk("sys_en_exp", en_exp, 32'd1);
        chk("sys_code", exp_code, 32'd8);
        chk("sys_epc", exp_epc, 32'h80001000);
        chk("sys_flush", flush, 32'd1);
        step();
        chk("sys_rvalid", redirect_valid, 32'd1);
        chk("sys_rpc", redirect_pc, 32'h80000180);
        step(); step();

        // ov in a delay slot, taken even with EXL set
        int_exl = 1'b1;
        commit(32'h80002004, 1'b1, 7'b0000010, 32'd0, 1'b0);
        chk("ov_epc", exp_epc, 32'h80002000);
        chk("ov_bd", exp_bd, 32'd1);
        chk("ov_code", exp_code, 32'd12);
        chk("ov_badv_we", exp_badv_we, 32'd0);
        chk("ov_en_exp", en_exp, 32'd1);
        int_exl = 1'b0;
        step(); step(); step();

        // interrupt beats a simultaneous ri
        allow_int = 1'b1; interrupt_mask = 8'h80; hardware_int_o = 6'b100000; special_int_vec = 1'b1;
        step();
        commit(32'h80001100, 1'b0, 7'b0010000, 32'd0, 1'b0);
        allow_int = 1'b0; hardware_int_o = 6'd0; special_int_vec = 1'b0;
        chk("int_code", exp_code, 32'd0);
        step();
        chk("int_rpc", redirect_pc, 32'h80000200);
        step(); step(); step();

        // store address fault with boot vector
        boot_exp_vec = 1'b1;
        commit(32'h80001200, 1'b0, 7'b0000001, 32'h80000003, 1'b1);
        chk("ades_code", exp_code, 32'd5);
        chk("ades_badv", exp_bad_vaddr, 32'h80000003);
        chk("ades_badv_we", exp_badv_we, 32'd1);
        step();
        chk("ades_rpc", redirect_pc, 32'hBFC00380);
        boot_exp_vec = 1'b0;
        step(); step();

        // adel_if outranks a data fault and reports the fetch PC
        commit(32'h80004000, 1'b0, 7'b0100001, 32'h12345678, 1'b0);
        chk("adelif_code", exp_code, 32'd4);
        chk("adelif_badv", exp_bad_vaddr, 32'h80004000);
        step(); step(); step();

        // eret with fetch stalling for three cycles
        epc = 32'h80003000; redirect_ready = 1'b0;
        commit(32'h80001300, 1'b0, 7'b1000000, 32'd0, 1'b0);
        chk("eret_clean", clean_exl, 32'd1);
        chk("eret_en_exp", en_exp, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("eret_rvalid", redirect_valid, 32'd1);
            chk("eret_rpc", redirect_pc, 32'h80003000);
        end
        redirect_ready = 1'b1;
        step();
        chk("eret_done_busy", busy, 32'd0);
        chk("eret_done_rvalid", redirect_valid, 32'd0);
        step();

        // commit ignored while halted
        stall = 1'b0;
        commit(32'h80001400, 1'b0, 7'b0000010, 32'd0, 1'b0);
        chk("halt_busy", busy, 32'd0);
        stall = 1'b1;
        step();

        // FLUSH held through halt, then reset during REDIRECT
        redirect_ready = 1'b0;
        commit(32'h80001500, 1'b0, 7'b0000100, 32'd0, 1'b0);
        chk("brk_code", exp_code, 32'd9);
        stall = 1'b0;
        step();
        chk("hold_flush1", flush, 32'd1);
        step();
        chk("hold_flush2", flush, 32'd1);
        stall = 1'b1;
        step();
        chk("brk_rvalid", redirect_valid, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_rvalid", redirect_valid, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_rpc", redirect_pc, 32'd0);
        #3 rst = 1'b0;
        redirect_ready = 1'b1;
        step();
        chk("post_rst_busy", busy, 32'd0);
        chk("post_rst_flush", flush, 32'd0);
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
